// File: rtl/data_mem_dumper_pkg.sv
// Shared CPU constants: opcodes, dump word width and the data-memory dumper state encodings.
package data_mem_dumper_pkg;

    localparam int unsigned DUMP_WORD_WIDTH = 32;

    // CPU major opcodes kept alongside the dumper encodings
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STALL = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4,
        ST_DONE  = 3'd5
    } dump_state_e;

    // The dump owns data memory, and so holds the CPU, from STALL through SEND
    function automatic logic stalls_cpu(input dump_state_e s);
        return (s == ST_STALL) || (s == ST_READ) || (s == ST_WAIT) || (s == ST_SEND);
    endfunction

endpackage

// File: rtl/data_mem_dumper.sv
// Dumps an inclusive range of data-memory words onto a valid/ready stream while stalling the CPU.
module data_mem_dumper
    import data_mem_dumper_pkg::*;
#(
    parameter int unsigned DATA_MEM_SIZE = 64,
    parameter int unsigned ADDR_WIDTH    = 6
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      first_addr,
    input  logic [ADDR_WIDTH-1:0]      last_addr,
    output logic                       cpu_stall,
    output logic                       mem_read_enable,
    output logic [ADDR_WIDTH-1:0]      mem_address,
    input  logic [DUMP_WORD_WIDTH-1:0] mem_read_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DUMP_WORD_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]      out_address,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       range_error
);

    if (ADDR_WIDTH != $clog2(DATA_MEM_SIZE)) begin : g_bad_addr_width
        $error("ADDR_WIDTH must equal clog2(DATA_MEM_SIZE)");
    end

    dump_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]      cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0]      last_addr_q, last_addr_d;
    logic                       cpu_stall_q, cpu_stall_d;
    logic                       mem_read_enable_q, mem_read_enable_d;
    logic [ADDR_WIDTH-1:0]      mem_address_q, mem_address_d;
    logic                       out_valid_q, out_valid_d;
    logic [DUMP_WORD_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0]      out_address_q, out_address_d;
    logic                       out_last_q, out_last_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       range_error_q, range_error_d;

    // Next state, address counter and output word capture
    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        last_addr_d   = last_addr_q;
        out_data_d    = out_data_q;
        out_address_d = out_address_q;
        out_last_d    = out_last_q;
        range_error_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_d  = first_addr;
                    last_addr_d = last_addr;
                    if (first_addr > last_addr) begin
                        state_d       = ST_DONE;
                        range_error_d = 1'b1;
                    end else begin
                        state_d = ST_STALL;
                    end
                end
            end
            ST_STALL: state_d = ST_READ;
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT: begin
                state_d       = ST_SEND;
                out_data_d    = mem_read_data;
                out_address_d = cur_addr_q;
                out_last_d    = (cur_addr_q == last_addr_q);
            end
            ST_SEND: begin
                if (out_ready) begin
                    // Stopping on equality keeps the counter from wrapping at the top word
                    if (cur_addr_q == last_addr_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
                        state_d    = ST_READ;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_comb begin
        cpu_stall_d       = stalls_cpu(state_d);
        busy_d            = (state_d != ST_IDLE);
        mem_read_enable_d = (state_d == ST_READ);
        mem_address_d     = (state_d == ST_READ) ? cur_addr_d : '0;
        out_valid_d       = (state_d == ST_SEND);
        done_d            = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            cur_addr_q        <= '0;
            last_addr_q       <= '0;
            cpu_stall_q       <= 1'b0;
            mem_read_enable_q <= 1'b0;
            mem_address_q     <= '0;
            out_valid_q       <= 1'b0;
            out_data_q        <= '0;
            out_address_q     <= '0;
            out_last_q        <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            range_error_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            cur_addr_q        <= cur_addr_d;
            last_addr_q       <= last_addr_d;
            cpu_stall_q       <= cpu_stall_d;
            mem_read_enable_q <= mem_read_enable_d;
            mem_address_q     <= mem_address_d;
            out_valid_q       <= out_valid_d;
            out_data_q        <= out_data_d;
            out_address_q     <= out_address_d;
            out_last_q        <= out_last_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            range_error_q     <= range_error_d;
        end
    end

    assign cpu_stall       = cpu_stall_q;
    assign mem_read_enable = mem_read_enable_q;
    assign mem_address     = mem_address_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_address     = out_address_q;
    assign out_last        = out_last_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign range_error     = range_error_q;

endmodule

// File: tb/tb_data_mem_dumper.sv
// Scoreboard bench for data_mem_dumper: a memory model feeds the DUT, expected words are queued at start.
module tb_data_mem_dumper;

    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic          cpu_stall;
    logic          mem_read_enable;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_read_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic [AW-1:0] out_address;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          range_error;

    typedef struct packed {
        logic [31:0]   data;
        logic [AW-1:0] addr;
        logic          last;
    } word_t;

    word_t       exp_q[$];
    word_t       mon_w;
    logic [31:0] mem [DEPTH];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          hs_count = 0;
    int          rd_count = 0;
    int          rd0_count = 0;
    int          stall_count = 0;

    data_mem_dumper dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .first_addr      (first_addr),
        .last_addr       (last_addr),
        .cpu_stall       (cpu_stall),
        .mem_read_enable (mem_read_enable),
        .mem_address     (mem_address),
        .mem_read_data   (mem_read_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_address     (out_address),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done),
        .range_error     (range_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous-read data memory model
    always @(posedge clock) begin
        if (mem_read_enable) mem_read_data <= mem[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Mid-cycle monitor: handshakes pop the scoreboard, activity counters feed later checks
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_read_enable) begin
                rd_count++;
                if (mem_address == AW'(0)) rd0_count++;
            end
            if (cpu_stall) stall_count++;
            if (out_valid && out_ready) begin
                hs_count++;
                hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", 32'd1, 32'd0);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("sb_data", out_data, mon_w.data);
                    check("sb_addr", 32'(out_address), 32'(mon_w.addr));
                    check("sb_last", 32'(out_last), 32'(mon_w.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_counts();
        hs_count    = 0;
        rd_count    = 0;
        rd0_count   = 0;
        stall_count = 0;
    endtask

    task automatic push_range(input int f, input int l);
        word_t w;
        for (int i = f; i <= l; i++) begin
            w.data = mem[i];
            w.addr = AW'(i);
            w.last = (i == l);
            exp_q.push_back(w);
        end
    endtask

    task automatic start_dump(input int f, input int l, output int s_cyc);
        first_addr = AW'(f);
        last_addr  = AW'(l);
        start      = 1'b1;
        s_cyc      = cyc;
        if (f <= l) push_range(f, l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int at_cyc);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
        at_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, output int at_cyc);
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check({tag, "_done_timeout"}, 32'd0, 32'd1);
        at_cyc = cyc;
    endtask

    task automatic wait_word(input int a, input string tag);
        int n = 0;
        while (!(out_valid && out_address == AW'(a)) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check({tag, "_word_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, out_data, 32'd0);
        check({tag, "_ctrl"},
              32'({cpu_stall, mem_read_enable, mem_address, out_valid, out_address,
                   out_last, busy, done, range_error}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int s;
        int v;
        int d;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h100 + 32'(4 * i);
        reset      = 1'b1;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        out_ready  = 1'b1;

        // Reset while idle
        repeat (3) tick();
        check_all_zero("rst_initial");
        reset = 1'b0;
        repeat (2) tick();
        #2 reset = 1'b1;
        #1 check_all_zero("rst_idle");
        tick();
        reset = 1'b0;
        tick();

        // Basic dump 0..3 with consumer always ready
        clear_counts();
        start_dump(0, 3, s);
        wait_valid("basic", v);
        check("basic_first_latency", 32'(v - s), 32'd4);
        wait_done("basic", d);
        check("basic_done_after_last_hs", 32'(d - hs_cyc), 32'd1);
        check("basic_no_range_err", 32'(range_error), 32'd0);
        check("basic_stall_low_in_done", 32'(cpu_stall), 32'd0);
        check("basic_word_count", 32'(hs_count), 32'd4);
        check("basic_sb_drained", 32'(exp_q.size()), 32'd0);
        tick();
        check("basic_done_one_cycle", 32'(done), 32'd0);
        check("basic_idle_not_busy", 32'(busy), 32'd0);

        // Backpressure on word 1
        clear_counts();
        start_dump(0, 3, s);
        wait_word(1, "bp");
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_data_held", out_data, 32'h104);
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_no_read", 32'(mem_read_enable), 32'd0);
            check("bp_stall_high", 32'(cpu_stall), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        wait_done("bp", d);
        check("bp_word_count", 32'(hs_count), 32'd4);
        check("bp_sb_drained", 32'(exp_q.size()), 32'd0);
        tick();

        // Top word only: no wrap to address 0
        clear_counts();
        start_dump(63, 63, s);
        wait_done("top", d);
        repeat (5) tick();
        check("top_word_count", 32'(hs_count), 32'd1);
        check("top_read_count", 32'(rd_count), 32'd1);
        check("top_no_addr0_read", 32'(rd0_count), 32'd0);
        check("top_sb_drained", 32'(exp_q.size()), 32'd0);

        // Reversed range
        clear_counts();
        start_dump(5, 2, s);
        check("range_done", 32'(done), 32'd1);
        check("range_error_pulse", 32'(range_error), 32'd1);
        check("range_busy_in_done", 32'(busy), 32'd1);
        tick();
        check("range_done_cleared", 32'(done), 32'd0);
        check("range_error_cleared", 32'(range_error), 32'd0);
        repeat (3) tick();
        check("range_no_reads", 32'(rd_count), 32'd0);
        check("range_no_stall", 32'(stall_count), 32'd0);
        check("range_no_words", 32'(hs_count), 32'd0);

        // Reset in SEND of word 2, with start pulses while busy
        clear_counts();
        start_dump(0, 7, s);
        wait_word(2, "mid");
        out_ready  = 1'b0;
        first_addr = AW'(9);
        last_addr  = AW'(9);
        start      = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        tick();
        check("mid_start_ignored_addr", 32'(out_address), 32'd2);
        check("mid_start_ignored_valid", 32'(out_valid), 32'd1);
        check("mid_words_before_reset", 32'(hs_count), 32'd2);
        #2 reset = 1'b1;
        #1 check_all_zero("mid_rst");
        exp_q.delete();
        repeat (2) tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        clear_counts();
        repeat (20) tick();
        check("mid_no_resume_words", 32'(hs_count), 32'd0);
        check("mid_no_resume_reads", 32'(rd_count), 32'd0);
        check("mid_no_resume_stall", 32'(stall_count), 32'd0);

        // Start accepted right after reset recovery
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_counts();
        start_dump(10, 11, s);
        wait_valid("post", v);
        check("post_first_latency", 32'(v - s), 32'd4);
        wait_done("post", d);
        check("post_word_count", 32'(hs_count), 32'd2);
        check("post_sb_drained", 32'(exp_q.size()), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_dumper.md
DATA_MEM_DUMPER -- requirements
Module: data_mem_dumper

Interface
REQ-001 Parameter DATA_MEM_SIZE, default 64, number of 32-bit data-memory words.
REQ-002 Parameter ADDR_WIDTH, default 6, word-address width; SHALL equal clog2(DATA_MEM_SIZE).
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request to dump a word range; sampled only in IDLE.
REQ-006 first_addr  in  ADDR_WIDTH  first word address; latched when start is accepted.
REQ-007 last_addr  in  ADDR_WIDTH  last word address, inclusive; latched with first_addr.
REQ-008 cpu_stall  out  1  holds the CPU pipeline while the dump owns data memory.
REQ-009 mem_read_enable  out  1  read strobe to data memory.
REQ-010 mem_address  out  ADDR_WIDTH  word address to data memory.
REQ-011 mem_read_data  in  32  synchronous-read data, valid the cycle after the strobe.
REQ-012 out_valid  out  1  out_data/out_address/out_last are valid.
REQ-013 out_ready  in  1  consumer accepts the word when high with out_valid.
REQ-014 out_data  out  32  dumped word.
REQ-015 out_address  out  ADDR_WIDTH  address of out_data.
REQ-016 out_last  out  1  out_data is the word at last_addr.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse at end of dump.
REQ-019 range_error  out  1  one-cycle pulse, coincident with done, when first_addr > last_addr.

Function
REQ-020 FSM states: IDLE, STALL, READ, WAIT, SEND, DONE; registered, one state per cycle except SEND.
REQ-021 IDLE -> STALL on start=1, latching both addresses; if first_addr > last_addr, IDLE -> DONE with range_error and no memory read.
REQ-022 STALL: cpu_stall=1, no read; one cycle for the in-flight CPU store to complete; -> READ.
REQ-023 READ: mem_read_enable=1, mem_address=current address; -> WAIT.
REQ-024 WAIT: mem_read_data captured into out_data on the exiting edge; out_address set to the current address; -> SEND.
REQ-025 SEND: out_valid=1; out_data/out_address/out_last stable until out_ready=1; no memory reads.
REQ-026 On SEND handshake: if current address == last_addr, -> DONE; else increment the address and -> READ.
REQ-027 Address never wraps: last_addr = DATA_MEM_SIZE-1 ends the dump without incrementing past it.
REQ-028 DONE: done=1 for one cycle, cpu_stall=0; -> IDLE.
REQ-029 cpu_stall=1 in STALL, READ, WAIT and SEND only.
REQ-030 Latency: first out_valid appears 4 cycles after the edge that samples start; 3 cycles per word with out_ready held high.
REQ-031 start is ignored while busy=1; no queuing.
REQ-032 mem_read_enable=0 and mem_address=0 outside READ.

Reset
REQ-033 reset=1 immediately forces IDLE and drives every output to 0, including mid-dump; cpu_stall drops asynchronously.
REQ-034 After reset deasserts, the first start is accepted on the next rising edge; no partial dump resumes.

Structure
REQ-035 FSM state encodings and DUMP_WORD_WIDTH=32 SHALL live in the shared constants header with the CPU opcodes.
REQ-036 Single flat module with no sub-module; the address counter and output register are inline.

Verification
REQ-037 Reset: assert reset mid-idle -> all outputs 0, busy=0.
REQ-038 Memory data[i]=0x100+4*i; start with first=0, last=3, out_ready=1 -> words 0x100, 0x104, 0x108, 0x10C at addresses 0..3; out_last only on 0x10C; first out_valid 4 cycles after start; done 1 cycle after the last handshake.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles on word 1 -> out_data stays 0x104, mem_read_enable=0, cpu_stall=1 throughout.
REQ-040 Boundary: first=last=63 -> exactly one word 0x1FC, out_last=1, no address 0 read afterwards.
REQ-041 Range error: first=5, last=2 -> done and range_error pulse together 1 cycle later; mem_read_enable never high; cpu_stall never high.
REQ-042 Reset mid-dump (in SEND of word 2 of 0..7) plus start pulses while busy -> outputs 0 and cpu_stall=0 immediately; starts while busy produce no extra words.
